// File: rtl/osc_pkg.sv
// Shared definitions for the two-case oscillator and its case scheduler.
// State encoding is 3 bits so the scheduler FSM and any debug taps agree on values.
package osc_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_SWITCH  = 3'd2,
        S_CONFIRM = 3'd3,
        S_DWELL   = 3'd4
    } sched_state_e;

    localparam logic CASE0 = 1'b0;
    localparam logic CASE1 = 1'b1;

    localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/osc_rr_arb.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to rr_ptr_i.
module osc_rr_arb
    import osc_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               rr_ptr_i,
    output logic               idx_o,
    output logic               valid_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = (req_i == 2'b11) ? rr_ptr_i : req_i[1];
    end

endmodule

// File: rtl/osc_case_sched.sv
// Shares one two-case oscillator between two requesters: arbitrates, pulses x to swap case,
// confirms the swap from osc_state[1], then holds off further grants for DWELL cycles.
module osc_case_sched
    import osc_pkg::*;
#(
    parameter int unsigned DWELL   = 4,
    parameter int unsigned TIMEOUT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [1:0]   tgt,
    input  logic [1:0]   osc_state,
    output logic         x,
    output logic [1:0]   gnt,
    output logic         done,
    output logic         err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;

    sched_state_e  state_q, state_d;
    logic          idx_q, idx_d;
    logic          target_q, target_d;
    logic          rr_q, rr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [1:0]    masked_req;
    logic          arb_idx;
    logic          arb_valid;

    // A requester still sees its own grant pulse with req high; keep it out of arbitration.
    assign masked_req = req & ~gnt_q;

    osc_rr_arb u_arb (
        .req_i    (masked_req),
        .rr_ptr_i (rr_q),
        .idx_o    (arb_idx),
        .valid_o  (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        target_d = target_q;
        rr_d     = rr_q;
        timer_d  = timer_q;
        dwell_d  = dwell_q;
        gnt_d    = 2'b00;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    idx_d    = arb_idx;
                    target_d = tgt[arb_idx];
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (osc_state[1] == target_q) begin
                    gnt_d   = 2'b01 << idx_q;
                    done_d  = 1'b1;
                    rr_d    = ~idx_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SWITCH;
                end
            end
            S_SWITCH: begin
                timer_d = '0;
                state_d = S_CONFIRM;
            end
            S_CONFIRM: begin
                if (osc_state[1] == target_q) begin
                    gnt_d   = 2'b01 << idx_q;
                    done_d  = 1'b1;
                    rr_d    = ~idx_q;
                    dwell_d = DW'(DWELL);
                    state_d = S_DWELL;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // Last allowed CONFIRM cycle still shows the old case: give up.
                    gnt_d   = 2'b01 << idx_q;
                    err_d   = 1'b1;
                    rr_d    = ~idx_q;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DWELL: begin
                if (dwell_q <= DW'(1)) begin
                    dwell_d = '0;
                    state_d = S_IDLE;
                end else begin
                    dwell_d = dwell_q - DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 1'b0;
            target_q <= CASE0;
            rr_q     <= 1'b0;
            timer_q  <= '0;
            dwell_q  <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            rr_q     <= rr_d;
            timer_q  <= timer_d;
            dwell_q  <= dwell_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign x    = (state_q == S_SWITCH);
    assign gnt  = gnt_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_osc_case_sched.sv
// Randomized bench for osc_case_sched with a behavioural oscillator and a transaction-level
// schedule model: each grant decision books its x/gnt/done/err cycles into expectation tables.
module tb_osc_case_sched;

    localparam int DWELL   = 4;
    localparam int TIMEOUT = 3;
    localparam int NCYC    = 2800;
    localparam int PAD     = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] tgt;
    logic [1:0] osc;
    logic       x;
    logic [1:0] gnt;
    logic       done;
    logic       err;
    logic       stuck;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_gnt  [0:NCYC+PAD-1];
    logic       exp_done [0:NCYC+PAD-1];
    logic       exp_err  [0:NCYC+PAD-1];
    logic       exp_x    [0:NCYC+PAD-1];

    always #5 clk = ~clk;

    osc_case_sched #(.DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tgt       (tgt),
        .osc_state (osc),
        .x         (x),
        .gnt       (gnt),
        .done      (done),
        .err       (err)
    );

    // Oscillator: bit0 toggles every cycle, x swaps case; 'stuck' models a swap that never lands.
    always @(posedge clk) begin
        if (!rst) osc <= 2'b00;
        else      osc <= {osc[1] ^ (x & ~stuck), ~osc[0]};
    end

    initial begin
        int next_free;
        int prio;
        int phase;
        int planned_rst;
        int win;
        logic [1:0] masked;

        next_free   = 0;
        prio        = 0;
        phase       = 0;
        planned_rst = -1;
        stuck       = 1'b0;
        rst         = 1'b0;
        req         = 2'b11;
        tgt         = 2'($urandom_range(0, 3));
        for (int j = 0; j < NCYC + PAD; j++) begin
            exp_gnt[j] = 2'b00; exp_done[j] = 1'b0; exp_err[j] = 1'b0; exp_x[j] = 1'b0;
        end

        for (int k = 0; k < NCYC; k++) begin
            @(posedge clk);
            #1;

            checks++;
            assert (gnt === exp_gnt[k]) else begin
                errors++; $error("FAIL gnt cyc=%0d observed=%b expected=%b", k, gnt, exp_gnt[k]);
            end
            checks++;
            assert (done === exp_done[k]) else begin
                errors++; $error("FAIL done cyc=%0d observed=%b expected=%b", k, done, exp_done[k]);
            end
            checks++;
            assert (err === exp_err[k]) else begin
                errors++; $error("FAIL err cyc=%0d observed=%b expected=%b", k, err, exp_err[k]);
            end
            checks++;
            assert (x === exp_x[k]) else begin
                errors++; $error("FAIL x cyc=%0d observed=%b expected=%b", k, x, exp_x[k]);
            end

            // Inputs for this cycle: requesters drop the cycle after their grant, else may raise.
            if (k > 0) begin
                for (int i = 0; i < 2; i++) begin
                    if (exp_gnt[k-1][i]) begin
                        req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        tgt[i] = 1'($urandom_range(0, 1));
                    end
                end
            end
            rst = !(k < 1 || k == planned_rst || (phase == 2 && $urandom_range(0, 99) == 0));

            if (k >= next_free && phase == 0 && k >= 1000) begin
                stuck = 1'b1; phase = 1;
            end else if (k >= next_free && phase == 1 && k >= 1700) begin
                stuck = 1'b0; phase = 2;
            end

            if (!rst) begin
                for (int j = k + 1; j < k + PAD && j < NCYC + PAD; j++) begin
                    exp_gnt[j] = 2'b00; exp_done[j] = 1'b0; exp_err[j] = 1'b0; exp_x[j] = 1'b0;
                end
                next_free = k + 1;
                prio      = 0;
            end else if (k >= next_free) begin
                masked = req & ~exp_gnt[k];
                if (masked != 2'b00) begin
                    win = (masked == 2'b11) ? prio : (masked[1] ? 1 : 0);
                    if (tgt[win] == osc[1]) begin
                        exp_gnt[k+2][win] = 1'b1;
                        exp_done[k+2]     = 1'b1;
                        next_free         = k + 2;
                    end else begin
                        exp_x[k+2] = 1'b1;
                        if (stuck) begin
                            exp_gnt[k+3+TIMEOUT][win] = 1'b1;
                            exp_err[k+3+TIMEOUT]      = 1'b1;
                            next_free                 = k + 3 + TIMEOUT;
                        end else begin
                            exp_gnt[k+4][win] = 1'b1;
                            exp_done[k+4]     = 1'b1;
                            next_free         = k + 4 + DWELL;
                            if (phase == 2 && $urandom_range(0, 1) == 0)
                                planned_rst = ($urandom_range(0, 1) == 0) ? k + 3 : k + 5;
                        end
                    end
                    prio = 1 - win;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
